booth4_mult_seq: RTL



---
 rtl/booth4_mult_seq_if.sv | 12 +
 rtl/booth4_mult_seq.sv | 76 +++++++
 2 files changed

// File: rtl/booth4_mult_seq_if.sv
// booth4_mult_seq_if: start/busy/done handshake, operands and product of the Booth multiplier
interface booth4_mult_seq_if #(parameter int WIDTH = 8);
  logic go;
  logic signed_mode;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic busy;
  logic done;
  logic [2*WIDTH-1:0] product;
  modport master(output go, signed_mode, mcand, mplier, input busy, done, product);
  modport slave(input go, signed_mode, mcand, mplier, output busy, done, product);
endinterface

// File: rtl/booth4_mult_seq.sv
// booth4_mult_seq: sequential radix-4 Booth multiplier, signed/unsigned per operation, fixed latency
// BOOTH_ZERO_SKIP_EN: a zero operand goes straight to DONE with product 0
module booth4_mult_seq #(parameter int WIDTH = 8) (
  input logic clock,
  input logic reset,
  booth4_mult_seq_if.slave bus
);
  localparam int ITERS = WIDTH / 2 + 1;
  localparam int CW = $clog2(ITERS + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH+1:0] m_q, m_d, a_q, a_d, m_cap, q_cap, m2, add, a_sum, a_n;
  logic [WIDTH+2:0] q_q, q_d, q_n;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic zero;
  assign m_cap = bus.signed_mode ? {{2{bus.mcand[WIDTH-1]}}, bus.mcand} : {2'b00, bus.mcand};
  assign q_cap = bus.signed_mode ? {{2{bus.mplier[WIDTH-1]}}, bus.mplier} : {2'b00, bus.mplier};
`ifdef BOOTH_ZERO_SKIP_EN
  assign zero = (bus.mcand == '0) || (bus.mplier == '0);
`else
  assign zero = 1'b0;
`endif
  assign m2 = {m_q[WIDTH:0], 1'b0};
  assign add = (q_q[2:0] == 3'b001 || q_q[2:0] == 3'b010) ? m_q :
               (q_q[2:0] == 3'b011) ? m2 :
               (q_q[2:0] == 3'b100) ? -m2 :
               (q_q[2:0] == 3'b101 || q_q[2:0] == 3'b110) ? -m_q : '0;
  assign a_sum = a_q + add;
  // the two guard bits of A carry the sign, so the shift fill is simply A'[WIDTH+1]
  assign {a_n, q_n} = $signed({a_sum, q_q}) >>> 2;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    m_d = m_q;
    q_d = q_q;
    a_d = a_q;
    product_d = product_q;
    if (bus.go && state_q != RUN) begin
      m_d = m_cap;
      q_d = {q_cap, 1'b0};
      a_d = '0;
      cnt_d = zero ? '0 : CW'(ITERS);
      state_d = zero ? DONE : RUN;
      product_d = zero ? '0 : product_q;
    end else if (state_q == RUN) begin
      a_d = a_n;
      q_d = q_n;
      cnt_d = cnt_q - 1'b1;
      state_d = (cnt_q == CW'(1)) ? DONE : RUN;
      product_d = (cnt_q == CW'(1)) ? {a_n[WIDTH-3:0], q_n[WIDTH+2:1]} : product_q;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      m_q <= '0;
      q_q <= '0;
      a_q <= '0;
      product_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      m_q <= m_d;
      q_q <= q_d;
      a_q <= a_d;
      product_q <= product_d;
    end
  end
  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
  assign bus.product = product_q;
endmodule
